msu_regs_v2: RTL and testbench
==============================

Name: msu_regs_v2

Overview:
- Parametrised MSU-1 register interface for the SNES bus. Full seek/data/track/volume/control register semantics.
- Owns the HPS side through two req/ack handshakes (data seek, audio track) plus a data prefetch FIFO that the HPS streams into.
- Sits between the cartridge bus decode (ENABLE) and the HPS file-streaming logic; successor to the first-generation status/ID-only MSU block.

Parameters:
- BASE, 16'h2000, register window base; offsets 0..7 are decoded on ADDR[15:0].
- FIFO_DEPTH, 16, data prefetch FIFO entries; power of two, minimum 2.
- REVISION, 3'd2, value reported in MSU_STATUS[2:0].
- ID_LAST, "1", sixth byte of the ID string "S-MSU" + ID_LAST.

Ports:
- CLK  in  1  clock
- RST_N  in  1  reset, synchronous, active-low
- ENABLE  in  1  chip select from bus decode
- RD_N  in  1  bus read strobe, active-low
- WR_N  in  1  bus write strobe, active-low
- ADDR  in  24  bus address; only [15:0] decoded
- DIN  in  8  bus write data
- DOUT  out  8  bus read data, registered
- seek_addr  out  32  committed data seek address
- seek_req  out  1  data seek request to HPS
- seek_ack  in  1  HPS seek accepted
- fifo_din  in  8  HPS data byte
- fifo_valid  in  1  HPS byte valid
- fifo_ready  out  1  FIFO can accept a byte
- rd_addr  out  32  seek_addr plus bytes consumed (debug)
- track_out  out  16  committed track number
- track_req  out  1  track load request to HPS
- track_ack  in  1  HPS track load done
- track_missing_in  in  1  sampled with track_ack
- audio_end  in  1  one-cycle pulse, end of track reached
- volume_out  out  8  MSU volume
- playing_out  out  1  audio play state
- repeat_out  out  1  audio repeat state

Behaviour:
- Access detection
  - rd_acc = ENABLE & ~RD_N; wr_acc = ENABLE & ~WR_N.
  - Action fires once per access, on the cycle the registered previous value was 0 and the current value is 1.
  - A held strobe never retriggers.
  - If both strobes rise in the same cycle, the write is processed and the read is ignored.
- Reset
  - All outputs 0; DOUT = 8'h00.
  - FIFO empty; shadow registers 0; all status bits 0.
  - Reset during a handshake drops seek_req and track_req in the next cycle.
- Seek
  - Writes to offsets 0..3 load seek_shadow bytes [7:0], [15:8], [23:16], [31:24].
  - The offset-3 write also commits:
    - seek_addr <= {DIN, shadow[23:0]}; rd_addr <= same value.
    - FIFO flushed; data_busy = 1; seek_req = 1 in the next cycle.
  - seek_req is held until seek_ack = 1 is sampled, then cleared in the following cycle.
  - fifo_ready = ~seek_req & (count < FIFO_DEPTH). Bytes arriving while not ready are dropped.
  - data_busy clears on the first cycle with seek_req = 0 and count >= 1.
  - A new commit during data_busy restarts the sequence.
  - A commit in the same cycle as fifo_valid: the commit wins and the byte is dropped.
- Data read (offset 1)
  - data_busy = 0 and FIFO non-empty: DOUT <= head; pop; rd_addr += 1 (32-bit wrap).
  - Otherwise: DOUT <= 8'h00, with no pop.
  - Simultaneous pop and push is allowed; count is unchanged.
- Status read (offset 0)
  - DOUT <= {data_busy, audio_busy, repeat, playing, track_missing, REVISION}.
- ID reads
  - Reads of offsets 2..7 return "S", "-", "M", "S", "U", ID_LAST.
  - Reads have no other side effects.
- Track
  - Offset 4 write: shadow LSB.
  - Offset 5 write:
    - track_out <= {DIN, lsb}.
    - audio_busy = 1; playing = 0; repeat = 0.
    - track_req = 1 next cycle, held until track_ack.
  - On the track_ack cycle: track_missing <= track_missing_in; audio_busy = 0.
- Volume
  - Offset 6 write: volume_out <= DIN, effective the next cycle.
- Control (offset 7 write)
  - Ignored while audio_busy.
  - Otherwise: playing <= DIN[0] & ~track_missing; repeat <= DIN[1].
- audio_end
  - With repeat = 1: no state change.
  - Otherwise: playing <= 0.
  - If audio_end coincides with a control write, the control write wins.
- Latency
  - Register write to output: 1 cycle.
  - Read access edge to DOUT: 1 cycle.

Decomposition:
- Shared package msu_pkg holds:
  - Register offset constants OFF_STATUS..OFF_CONTROL.
  - Status bit indices.
  - The "S-MSU" ID byte constants.
- One sub-module: msu_fifo.
  - Synchronous FIFO, parametrised depth.
  - Ports: push, pop, flush, din, dout, count, empty, full.
  - flush has priority over push and pop.

Test Plan:
1. After reset, read offsets 0..7 -> 8'h02, 8'h00, "S", "-", "M", "S", "U", "1"; all outputs 0.
2. Write 0x78, 0x56, 0x34, 0x12 to offsets 0..3 -> seek_addr = 0x12345678 and seek_req high. Read status -> bit7 = 1. Ack, then push 0xA5 -> data_busy = 0. Read offset 1 -> 0xA5; rd_addr = 0x12345679.
3. Fill the FIFO with 16 bytes -> fifo_ready = 0 and a 17th byte is dropped. Perform 16 reads -> bytes returned in order; a further read returns 0x00 with rd_addr unchanged.
4. Write track 0x0102 -> track_req high and status bit6 = 1. Ack with track_missing_in = 1 -> status = 8'h0A. A control write of 0x03 then leaves playing = 0 and repeat = 1.
5. With a valid track, control 0x01 -> playing = 1; audio_end -> playing = 0. Control 0x03 followed by audio_end -> still playing.
6. Hold RD_N low for 10 cycles on offset 1 -> exactly one pop. Assert RST_N low mid seek_req -> seek_req = 0 and the FIFO is empty.

Source files
------------

// File: rtl/msu_pkg.sv
// Shared MSU-1 register map: offsets, status layout and ID string bytes.
package msu_pkg;

  localparam logic [2:0] OFF_STATUS   = 3'd0;
  localparam logic [2:0] OFF_DATA     = 3'd1;
  localparam logic [2:0] OFF_SEEK0    = 3'd0;
  localparam logic [2:0] OFF_SEEK1    = 3'd1;
  localparam logic [2:0] OFF_SEEK2    = 3'd2;
  localparam logic [2:0] OFF_SEEK3    = 3'd3;
  localparam logic [2:0] OFF_TRACK_LO = 3'd4;
  localparam logic [2:0] OFF_TRACK_HI = 3'd5;
  localparam logic [2:0] OFF_VOLUME   = 3'd6;
  localparam logic [2:0] OFF_CONTROL  = 3'd7;

  localparam int ST_DATA_BUSY     = 7;
  localparam int ST_AUDIO_BUSY    = 6;
  localparam int ST_REPEAT        = 5;
  localparam int ST_PLAYING       = 4;
  localparam int ST_TRACK_MISSING = 3;

  localparam logic [7:0] ID_BYTE_S    = 8'h53;
  localparam logic [7:0] ID_BYTE_DASH = 8'h2D;
  localparam logic [7:0] ID_BYTE_M    = 8'h4D;
  localparam logic [7:0] ID_BYTE_U    = 8'h55;

  typedef struct packed {
    logic       data_busy;
    logic       audio_busy;
    logic       rep;
    logic       playing;
    logic       track_missing;
    logic [2:0] revision;
  } status_t;

  // Offsets 2..7 spell "S-MSU" followed by the build-specific last byte.
  function automatic logic [7:0] id_byte(input logic [2:0] off, input logic [7:0] last);
    case (off)
      3'd2:    id_byte = ID_BYTE_S;
      3'd3:    id_byte = ID_BYTE_DASH;
      3'd4:    id_byte = ID_BYTE_M;
      3'd5:    id_byte = ID_BYTE_S;
      3'd6:    id_byte = ID_BYTE_U;
      default: id_byte = last;
    endcase
  endfunction

endpackage

// File: rtl/msu_fifo.sv
// Byte FIFO for the data prefetch path; head is visible combinationally on dout_o.
// Flush beats push and pop; push while full and pop while empty are ignored.
module msu_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic                    flush_i,
  input  logic [7:0]              din_i,
  output logic [7:0]              dout_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    empty_o,
  output logic                    full_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/msu_regs_v2.sv
// MSU-1 SNES register window with seek/track req-ack handshakes to the HPS and a data prefetch FIFO.
// Writes take effect and reads land on DOUT one cycle after the strobe edge; HPS bytes drop while fifo_ready is low.
module msu_regs_v2
  import msu_pkg::*;
#(
  parameter logic [15:0] BASE       = 16'h2000,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [2:0]  REVISION   = 3'd2,
  parameter logic [7:0]  ID_LAST    = "1"
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        ENABLE,
  input  logic        RD_N,
  input  logic        WR_N,
  input  logic [23:0] ADDR,
  input  logic [7:0]  DIN,
  output logic [7:0]  DOUT,
  output logic [31:0] seek_addr,
  output logic        seek_req,
  input  logic        seek_ack,
  input  logic [7:0]  fifo_din,
  input  logic        fifo_valid,
  output logic        fifo_ready,
  output logic [31:0] rd_addr,
  output logic [15:0] track_out,
  output logic        track_req,
  input  logic        track_ack,
  input  logic        track_missing_in,
  input  logic        audio_end,
  output logic [7:0]  volume_out,
  output logic        playing_out,
  output logic        repeat_out
);

  logic        rd_acc, wr_acc, rd_acc_q, wr_acc_q;
  logic        rd_edge, wr_edge, rd_fire, wr_fire;
  logic [15:0] off_full;
  logic [2:0]  off;
  logic        in_win;
  logic        unused_addr_hi;

  logic [23:0] seek_shadow_q, seek_shadow_d;
  logic [31:0] seek_addr_q, seek_addr_d, rd_addr_q, rd_addr_d;
  logic        seek_req_q, seek_req_d, data_busy_q, data_busy_d;
  logic [7:0]  track_lsb_q, track_lsb_d;
  logic [15:0] track_q, track_d;
  logic        track_req_q, track_req_d, audio_busy_q, audio_busy_d;
  logic        track_missing_q, track_missing_d;
  logic        playing_q, playing_d, repeat_q, repeat_d;
  logic [7:0]  volume_q, volume_d, dout_q, dout_d;

  logic                          seek_commit, fifo_push, fifo_pop;
  logic [7:0]                    fifo_head;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          fifo_empty, fifo_full;
  status_t                       status;

  assign rd_acc   = ENABLE & ~RD_N;
  assign wr_acc   = ENABLE & ~WR_N;
  assign rd_edge  = rd_acc & ~rd_acc_q;
  assign wr_edge  = wr_acc & ~wr_acc_q;
  assign off_full = ADDR[15:0] - BASE;
  assign in_win   = (off_full[15:3] == '0);
  assign off      = off_full[2:0];
  assign unused_addr_hi = ^ADDR[23:16];

  // A write edge masks a coincident read edge even when the read alone would hit.
  assign wr_fire = wr_edge & in_win;
  assign rd_fire = rd_edge & ~wr_edge & in_win;

  assign seek_commit = wr_fire & (off == OFF_SEEK3);
  assign fifo_ready  = ~seek_req_q & ~fifo_full;
  assign fifo_push   = fifo_valid & fifo_ready & ~seek_commit;
  assign fifo_pop    = rd_fire & (off == OFF_DATA) & ~data_busy_q & ~fifo_empty;

  assign status = '{data_busy: data_busy_q, audio_busy: audio_busy_q, rep: repeat_q,
                    playing: playing_q, track_missing: track_missing_q, revision: REVISION};

  msu_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (seek_commit),
    .din_i   (fifo_din),
    .dout_o  (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_comb begin
    seek_shadow_d   = seek_shadow_q;
    seek_addr_d     = seek_addr_q;
    rd_addr_d       = rd_addr_q;
    seek_req_d      = seek_req_q;
    data_busy_d     = data_busy_q;
    track_lsb_d     = track_lsb_q;
    track_d         = track_q;
    track_req_d     = track_req_q;
    audio_busy_d    = audio_busy_q;
    track_missing_d = track_missing_q;
    playing_d       = playing_q;
    repeat_d        = repeat_q;
    volume_d        = volume_q;
    dout_d          = dout_q;

    if (seek_req_q && seek_ack) seek_req_d = 1'b0;
    if (data_busy_q && !seek_req_q && (fifo_count != '0)) data_busy_d = 1'b0;
    if (track_req_q && track_ack) begin
      track_req_d     = 1'b0;
      audio_busy_d    = 1'b0;
      track_missing_d = track_missing_in;
    end
    if (audio_end && !repeat_q) playing_d = 1'b0;

    // Bus writes come last so they override the handshake and audio_end updates above.
    if (wr_fire) begin
      case (off)
        OFF_SEEK0: seek_shadow_d[7:0]   = DIN;
        OFF_SEEK1: seek_shadow_d[15:8]  = DIN;
        OFF_SEEK2: seek_shadow_d[23:16] = DIN;
        OFF_SEEK3: begin
          seek_addr_d = {DIN, seek_shadow_q};
          rd_addr_d   = {DIN, seek_shadow_q};
          seek_req_d  = 1'b1;
          data_busy_d = 1'b1;
        end
        OFF_TRACK_LO: track_lsb_d = DIN;
        OFF_TRACK_HI: begin
          track_d      = {DIN, track_lsb_q};
          track_req_d  = 1'b1;
          audio_busy_d = 1'b1;
          playing_d    = 1'b0;
          repeat_d     = 1'b0;
        end
        OFF_VOLUME: volume_d = DIN;
        OFF_CONTROL: begin
          if (!audio_busy_q) begin
            playing_d = DIN[0] & ~track_missing_q;
            repeat_d  = DIN[1];
          end
        end
        default: ;
      endcase
    end

    if (rd_fire) begin
      case (off)
        OFF_STATUS: dout_d = status;
        OFF_DATA: begin
          if (fifo_pop) begin
            dout_d    = fifo_head;
            rd_addr_d = rd_addr_q + 32'd1;
          end else begin
            dout_d = 8'h00;
          end
        end
        default: dout_d = id_byte(off, ID_LAST);
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rd_acc_q        <= 1'b0;
      wr_acc_q        <= 1'b0;
      seek_shadow_q   <= '0;
      seek_addr_q     <= '0;
      rd_addr_q       <= '0;
      seek_req_q      <= 1'b0;
      data_busy_q     <= 1'b0;
      track_lsb_q     <= '0;
      track_q         <= '0;
      track_req_q     <= 1'b0;
      audio_busy_q    <= 1'b0;
      track_missing_q <= 1'b0;
      playing_q       <= 1'b0;
      repeat_q        <= 1'b0;
      volume_q        <= '0;
      dout_q          <= 8'h00;
    end else begin
      rd_acc_q        <= rd_acc;
      wr_acc_q        <= wr_acc;
      seek_shadow_q   <= seek_shadow_d;
      seek_addr_q     <= seek_addr_d;
      rd_addr_q       <= rd_addr_d;
      seek_req_q      <= seek_req_d;
      data_busy_q     <= data_busy_d;
      track_lsb_q     <= track_lsb_d;
      track_q         <= track_d;
      track_req_q     <= track_req_d;
      audio_busy_q    <= audio_busy_d;
      track_missing_q <= track_missing_d;
      playing_q       <= playing_d;
      repeat_q        <= repeat_d;
      volume_q        <= volume_d;
      dout_q          <= dout_d;
    end
  end

  assign DOUT        = dout_q;
  assign seek_addr   = seek_addr_q;
  assign seek_req    = seek_req_q;
  assign rd_addr     = rd_addr_q;
  assign track_out   = track_q;
  assign track_req   = track_req_q;
  assign volume_out  = volume_q;
  assign playing_out = playing_q;
  assign repeat_out  = repeat_q;

endmodule

// File: tb/tb_msu_regs_v2.sv
// Bench for msu_regs_v2: directed register scenarios plus randomized bus/HPS traffic against a behavioural model.
module tb_msu_regs_v2;

  localparam logic [15:0] BASE  = 16'h2000;
  localparam int          DEPTH = 16;

  logic        CLK, RST_N, ENABLE, RD_N, WR_N;
  logic [23:0] ADDR;
  logic [7:0]  DIN, DOUT;
  logic [31:0] seek_addr, rd_addr;
  logic        seek_req, seek_ack;
  logic [7:0]  fifo_din;
  logic        fifo_valid, fifo_ready;
  logic [15:0] track_out;
  logic        track_req, track_ack, track_missing_in, audio_end;
  logic [7:0]  volume_out;
  logic        playing_out, repeat_out;

  msu_regs_v2 #(.BASE(BASE), .FIFO_DEPTH(DEPTH), .REVISION(3'd2), .ID_LAST("1")) dut (
    .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .RD_N(RD_N), .WR_N(WR_N),
    .ADDR(ADDR), .DIN(DIN), .DOUT(DOUT),
    .seek_addr(seek_addr), .seek_req(seek_req), .seek_ack(seek_ack),
    .fifo_din(fifo_din), .fifo_valid(fifo_valid), .fifo_ready(fifo_ready),
    .rd_addr(rd_addr), .track_out(track_out), .track_req(track_req),
    .track_ack(track_ack), .track_missing_in(track_missing_in), .audio_end(audio_end),
    .volume_out(volume_out), .playing_out(playing_out), .repeat_out(repeat_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  // Behavioural model: register file as plain variables, prefetch FIFO as a queue.
  bit          m_rd_prev, m_wr_prev;
  logic [23:0] m_shadow;
  logic [31:0] m_seek_addr, m_rd_addr;
  bit          m_seek_req, m_data_busy;
  logic [7:0]  m_q[$];
  logic [7:0]  m_track_lsb, m_vol, m_dout;
  logic [15:0] m_track;
  bit          m_track_req, m_audio_busy, m_missing, m_playing, m_repeat;
  logic [7:0]  id_tab [6] = '{"S", "-", "M", "S", "U", "1"};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit rd, wr, wr_new, rd_new, hit, commit, ready;
    bit old_req, old_busy, old_abusy, old_missing, old_repeat;
    int old_cnt, o;
    logic [15:0] off16;
    logic [7:0] status;
    if (!RST_N) begin
      m_rd_prev = 0; m_wr_prev = 0; m_shadow = 0; m_seek_addr = 0; m_rd_addr = 0;
      m_seek_req = 0; m_data_busy = 0; m_q.delete(); m_track_lsb = 0; m_vol = 0;
      m_dout = 0; m_track = 0; m_track_req = 0; m_audio_busy = 0; m_missing = 0;
      m_playing = 0; m_repeat = 0;
      return;
    end
    rd = ENABLE && !RD_N;
    wr = ENABLE && !WR_N;
    wr_new = wr && !m_wr_prev;
    rd_new = rd && !m_rd_prev && !wr_new;
    m_rd_prev = rd;
    m_wr_prev = wr;
    off16 = ADDR[15:0] - BASE;
    hit = off16 < 16'd8;
    o = int'(off16);
    old_req = m_seek_req; old_busy = m_data_busy; old_cnt = m_q.size();
    old_abusy = m_audio_busy; old_missing = m_missing; old_repeat = m_repeat;
    status = {m_data_busy, m_audio_busy, m_repeat, m_playing, m_missing, 3'd2};
    ready = !old_req && old_cnt < DEPTH;
    commit = wr_new && hit && o == 3;

    if (rd_new && hit) begin
      if (o == 0) m_dout = status;
      else if (o == 1) begin
        if (!old_busy && old_cnt > 0) begin
          m_dout = m_q.pop_front();
          m_rd_addr = m_rd_addr + 1;
        end else m_dout = 8'h00;
      end else m_dout = id_tab[o-2];
    end
    if (fifo_valid && ready && !commit) m_q.push_back(fifo_din);
    if (old_req && seek_ack) m_seek_req = 0;
    if (old_busy && !old_req && old_cnt > 0) m_data_busy = 0;
    if (m_track_req && track_ack) begin
      m_track_req = 0; m_audio_busy = 0; m_missing = track_missing_in;
    end
    if (audio_end && !old_repeat) m_playing = 0;
    if (wr_new && hit) begin
      case (o)
        0: m_shadow[7:0] = DIN;
        1: m_shadow[15:8] = DIN;
        2: m_shadow[23:16] = DIN;
        3: begin
          m_seek_addr = {DIN, m_shadow};
          m_rd_addr = m_seek_addr;
          m_q.delete();
          m_seek_req = 1; m_data_busy = 1;
        end
        4: m_track_lsb = DIN;
        5: begin
          m_track = {DIN, m_track_lsb};
          m_track_req = 1; m_audio_busy = 1; m_playing = 0; m_repeat = 0;
        end
        6: m_vol = DIN;
        default: if (!old_abusy) begin
          m_playing = DIN[0] && !old_missing;
          m_repeat = DIN[1];
        end
      endcase
    end
  endtask

  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("DOUT", DOUT, m_dout);
      chk("seek_addr", seek_addr, m_seek_addr);
      chk("seek_req", seek_req, m_seek_req);
      chk("fifo_ready", fifo_ready, !m_seek_req && m_q.size() < DEPTH);
      chk("rd_addr", rd_addr, m_rd_addr);
      chk("track_out", track_out, m_track);
      chk("track_req", track_req, m_track_req);
      chk("volume_out", volume_out, m_vol);
      chk("playing_out", playing_out, m_playing);
      chk("repeat_out", repeat_out, m_repeat);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    model_update();
  endtask

  task automatic bus_write(input logic [2:0] o, input logic [7:0] v);
    ENABLE = 1; WR_N = 0; ADDR = {8'h00, BASE + 16'(o)}; DIN = v;
    tick();
    WR_N = 1; ENABLE = 0;
    tick();
  endtask

  task automatic bus_read(input logic [2:0] o, output logic [7:0] d);
    ENABLE = 1; RD_N = 0; ADDR = {8'h00, BASE + 16'(o)};
    tick();
    d = DOUT;
    RD_N = 1; ENABLE = 0;
    tick();
  endtask

  task automatic pulse(input int which);
    if (which == 0) seek_ack = 1; else if (which == 1) track_ack = 1; else audio_end = 1;
    tick();
    seek_ack = 0; track_ack = 0; audio_end = 0; track_missing_in = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    n_errors++;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [7:0] exp_rst [8] = '{8'h02, 8'h00, "S", "-", "M", "S", "U", "1"};
    int hold, gap, kind, o;
    RST_N = 0; ENABLE = 0; RD_N = 1; WR_N = 1; ADDR = 0; DIN = 0;
    seek_ack = 0; fifo_din = 0; fifo_valid = 0; track_ack = 0;
    track_missing_in = 0; audio_end = 0;
    tick();
    cmp_en = 1;
    tick(); tick();
    RST_N = 1;
    tick();

    // Reset values and ID string
    chk("rst_seek_addr", seek_addr, 32'h0);
    chk("rst_track_out", track_out, 16'h0);
    chk("rst_volume", volume_out, 8'h0);
    chk("rst_dout", DOUT, 8'h00);
    for (int i = 0; i < 8; i++) begin
      bus_read(3'(i), d);
      chk($sformatf("rst_read_off%0d", i), d, exp_rst[i]);
    end

    // Seek commit, status while busy, ack, first byte
    bus_write(0, 8'h78); bus_write(1, 8'h56); bus_write(2, 8'h34); bus_write(3, 8'h12);
    chk("seek_addr_commit", seek_addr, 32'h12345678);
    chk("seek_req_set", seek_req, 1'b1);
    bus_read(0, d);
    chk("status_data_busy", d, 8'h82);
    pulse(0);
    chk("seek_req_clear", seek_req, 1'b0);
    fifo_valid = 1; fifo_din = 8'hA5;
    tick();
    fifo_valid = 0;
    tick();
    bus_read(0, d);
    chk("status_not_busy", d, 8'h02);
    bus_read(1, d);
    chk("data_first", d, 8'hA5);
    chk("rd_addr_inc", rd_addr, 32'h12345679);

    // FIFO fill to capacity, overflow drop, ordered drain, empty read
    fifo_valid = 1;
    for (int i = 0; i < 17; i++) begin
      fifo_din = 8'h20 + 8'(i);
      tick();
      if (i == 15) chk("fifo_full_ready", fifo_ready, 1'b0);
    end
    fifo_valid = 0;
    for (int i = 0; i < 16; i++) begin
      bus_read(1, d);
      chk($sformatf("drain_%0d", i), d, 8'h20 + 8'(i));
    end
    bus_read(1, d);
    chk("empty_read", d, 8'h00);
    chk("empty_rd_addr", rd_addr, 32'h12345689);

    // Track load with missing file, then control
    bus_write(4, 8'h02); bus_write(5, 8'h01);
    chk("track_out", track_out, 16'h0102);
    chk("track_req_set", track_req, 1'b1);
    bus_read(0, d);
    chk("status_audio_busy", d, 8'h42);
    track_missing_in = 1;
    pulse(1);
    bus_read(0, d);
    chk("status_missing", d, 8'h0A);
    bus_write(7, 8'h03);
    chk("missing_playing", playing_out, 1'b0);
    chk("missing_repeat", repeat_out, 1'b1);

    // Valid track, play and audio_end with/without repeat
    bus_write(5, 8'h00);
    pulse(1);
    bus_write(7, 8'h01);
    chk("play_on", playing_out, 1'b1);
    pulse(2);
    chk("end_stops", playing_out, 1'b0);
    bus_write(7, 8'h03);
    pulse(2);
    chk("end_repeat", playing_out, 1'b1);
    bus_write(6, 8'h9C);
    chk("volume", volume_out, 8'h9C);

    // Held read strobe pops once; reset mid-handshake
    fifo_valid = 1;
    for (int i = 0; i < 3; i++) begin
      fifo_din = 8'hC1 + 8'(i);
      tick();
    end
    fifo_valid = 0;
    ENABLE = 1; RD_N = 0; ADDR = {8'h00, BASE + 16'd1};
    for (int i = 0; i < 10; i++) tick();
    RD_N = 1; ENABLE = 0;
    tick();
    chk("hold_one_pop_dout", DOUT, 8'hC1);
    chk("hold_one_pop_addr", rd_addr, 32'h1234568A);
    bus_read(1, d);
    chk("hold_next_byte", d, 8'hC2);
    bus_write(0, 8'h00); bus_write(1, 8'h10); bus_write(2, 8'h00); bus_write(3, 8'h00);
    chk("seek2_req", seek_req, 1'b1);
    RST_N = 0;
    tick();
    RST_N = 1;
    chk("rst_drops_req", seek_req, 1'b0);
    chk("rst_seek_addr2", seek_addr, 32'h0);
    tick();
    bus_read(1, d);
    chk("rst_fifo_empty", d, 8'h00);

    // Randomized traffic, checked cycle by cycle against the model
    hold = 0; gap = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (hold > 0) hold--;
      else if (gap > 0) begin
        RD_N = 1; WR_N = 1; ENABLE = ($urandom_range(0, 3) == 0);
        gap--;
      end else begin
        kind = $urandom_range(0, 9);
        o = $urandom_range(0, 9);
        ADDR = {8'($urandom), BASE + 16'(o)};
        DIN = 8'($urandom);
        ENABLE = ($urandom_range(0, 9) != 0);
        RD_N = !(kind >= 4);
        WR_N = !(kind <= 3 || kind == 9);
        hold = $urandom_range(0, 3);
        gap = $urandom_range(1, 3);
      end
      fifo_valid = $urandom_range(0, 1);
      fifo_din = 8'($urandom);
      seek_ack = ($urandom_range(0, 3) == 0);
      track_ack = ($urandom_range(0, 4) == 0);
      track_missing_in = ($urandom_range(0, 3) == 0);
      audio_end = ($urandom_range(0, 15) == 0);
      RST_N = ($urandom_range(0, 499) != 0);
      tick();
    end
    RST_N = 1; ENABLE = 0; RD_N = 1; WR_N = 1; fifo_valid = 0;
    seek_ack = 0; track_ack = 0; audio_end = 0;
    tick(); tick();
    cmp_en = 0;
    @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
